// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, FSM encodings and the column-major byte index helper.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_NB      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  // Column-major layout: byte k sits at row k%4, column k/4.
  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/aes_row_rotr.sv
// One state row, rotated right by one byte position when enabled; passes the row through otherwise.
module aes_row_rotr #(
  parameter int BYTE_W = 8,
  parameter int NCOL   = 4
) (
  input  logic                   en,
  input  logic [BYTE_W*NCOL-1:0] row_in,
  output logic [BYTE_W*NCOL-1:0] row_out
);

  // Column 0 occupies the top byte, so a right rotation moves the low byte to the top.
  always_comb begin
    if (en) begin
      row_out = {row_in[BYTE_W-1:0], row_in[BYTE_W*NCOL-1:BYTE_W]};
    end else begin
      row_out = row_in;
    end
  end

endmodule

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows: latches a state on start, rotates rows right over three clocks, holds result with done.
module inv_shift_rows
  import aes_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int NCOL   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enableInvShiftRows,
  input  logic [0:AES_STATE_W-1] state,
  output logic [0:AES_STATE_W-1] stateOut,
  output logic                   invShiftRowsDone,
  output logic                   invShiftRowsBusy,
  output logic [1:0]             dbg_state
);

  localparam int ROW_W = BYTE_W * NCOL;

  // Handshake: enableInvShiftRows is a start request accepted on a rising edge whenever the
  // block is not busy (IDLE or DONE); requests while busy are dropped. invShiftRowsDone
  // marks stateOut valid and stays high until the next accepted start or reset.

  fsm_e                   fsm_q, fsm_d;
  logic [1:0]             step_q, step_d;
  logic [0:AES_STATE_W-1] work_q, work_d;
  logic [0:AES_STATE_W-1] out_q, out_d;
  logic                   done_q, done_d;

  logic [ROW_W-1:0]       row_in  [AES_NB];
  logic [ROW_W-1:0]       row_out [AES_NB];
  logic [AES_NB-1:0]      row_en;
  logic [0:AES_STATE_W-1] work_rot;

  always_comb begin
    for (int r = 0; r < AES_NB; r++) begin
      row_in[r] = '0;
      for (int c = 0; c < NCOL; c++) begin
        row_in[r][(NCOL-1-c)*BYTE_W +: BYTE_W] = work_q[byte_idx(r, c)*BYTE_W +: BYTE_W];
      end
      // Row r needs r rotations in total, so it drops out once step reaches its index.
      row_en[r] = (fsm_q == SHIFT) && (r > int'(step_q));
    end
  end

  for (genvar gr = 0; gr < AES_NB; gr++) begin : g_row
    aes_row_rotr #(
      .BYTE_W (BYTE_W),
      .NCOL   (NCOL)
    ) u_rotr (
      .en      (row_en[gr]),
      .row_in  (row_in[gr]),
      .row_out (row_out[gr])
    );
  end

  always_comb begin
    work_rot = '0;
    for (int r = 0; r < AES_NB; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        work_rot[byte_idx(r, c)*BYTE_W +: BYTE_W] = row_out[r][(NCOL-1-c)*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    step_d = step_q;
    work_d = work_q;
    out_d  = out_q;
    done_d = done_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (enableInvShiftRows) begin
          work_d = state;
          step_d = 2'd0;
          done_d = 1'b0;
          fsm_d  = SHIFT;
        end
      end
      SHIFT: begin
        work_d = work_rot;
        if (step_q == 2'd2) begin
          out_d  = work_rot;
          done_d = 1'b1;
          step_d = 2'd0;
          fsm_d  = DONE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      default: begin
        fsm_d  = IDLE;
        step_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      step_q <= 2'd0;
      work_q <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      step_q <= step_d;
      work_q <= work_d;
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  assign stateOut         = out_q;
  assign invShiftRowsDone = done_q;
  assign invShiftRowsBusy = (fsm_q == SHIFT);
  assign dbg_state        = fsm_q;

endmodule

// File: tb/tb_inv_shift_rows.sv
// Directed and round-trip bench for inv_shift_rows.
module tb_inv_shift_rows;

  logic         clk;
  logic         rst;
  logic         start;
  logic [0:127] st_in;
  logic [0:127] st_out;
  logic         done;
  logic         busy;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];

  inv_shift_rows dut (
    .clk                (clk),
    .rst                (rst),
    .enableInvShiftRows (start),
    .state              (st_in),
    .stateOut           (st_out),
    .invShiftRowsDone   (done),
    .invShiftRowsBusy   (busy),
    .dbg_state          (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Encrypt-side ShiftRows: out[r][c] = in[r][(c + r) mod 4], column-major bytes.
  function automatic logic [0:127] shift_rows_enc(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[(4*c + r)*8 +: 8] = s[(4*((c + r) % 4) + r)*8 +: 8];
    return o;
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    st_in = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (st_out !== 128'h0 || done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold: out=%h done=%b busy=%b st=%0d want 0/0/0/0", st_out, done, busy, dbg_state);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic run_vector(input logic [0:127] vin, input logic [0:127] vexp, input string name);
    logic [0:127] prev_out;
    prev_out = st_out;
    start = 1'b1;
    st_in = vin;
    tick();
    start = 1'b0;
    st_in = rnd128();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: busy=%b done=%b want 1/0", name, busy, done);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || st_out !== prev_out) begin
        errors++;
        $display("FAIL %s_midway%0d: done=%b busy=%b out=%h want 0/1/%h", name, i, done, busy, st_out, prev_out);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || st_out !== vexp) begin
      errors++;
      $display("FAIL %s_result: done=%b busy=%b out=%h want 1/0/%h", name, done, busy, st_out, vexp);
    end
  endtask

  task automatic test_vectors();
    run_vector(128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h7a9f102789d5f50b2beffd9f3dca4ea7, "fips_c1");
    run_vector(128'h000102030405060708090a0b0c0d0e0f, 128'h000d0a0704010e0b0805020f0c090603, "index");
  endtask

  task automatic test_start_while_busy();
    start = 1'b1;
    st_in = 128'h000102030405060708090a0b0c0d0e0f;
    tick();
    st_in = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || st_out !== 128'h000d0a0704010e0b0805020f0c090603) begin
      errors++;
      $display("FAIL busy_ignore_result: done=%b busy=%b out=%h want 1/0/000d0a0704010e0b0805020f0c090603", done, busy, st_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || st_out !== 128'h000d0a0704010e0b0805020f0c090603) begin
        errors++;
        $display("FAIL busy_ignore_hold%0d: done=%b busy=%b out=%h", i, done, busy, st_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    st_in = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (st_out !== 128'h0 || done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: out=%h done=%b busy=%b st=%0d want 0/0/0/0", st_out, done, busy, dbg_state);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b done=%b want 0/0", busy, done);
    end
    run_vector(128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h7a9f102789d5f50b2beffd9f3dca4ea7, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [127:0] orig;
    logic [127:0] want;
    start = 1'b1;
    for (int n = 0; n < 500; n++) begin
      orig  = rnd128();
      st_in = shift_rows_enc(orig);
      exp_q.push_back(orig);
      tick();
      st_in = rnd128();
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept%0d: done=%b busy=%b want 0/1", n, done, busy);
      end
      tick();
      tick();
      tick();
      want = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || st_out !== want) begin
        errors++;
        $display("FAIL b2b_result%0d: done=%b out=%h want 1/%h", n, done, st_out, want);
      end
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    st_in = '0;
    test_reset();
    test_vectors();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
